w0rm_data_bus_arbiter: RTL and testbench
========================================

W0RM_DATA_BUS_ARBITER -- requirements
Module: w0rm_data_bus_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of all data buses.
REQ-002 Parameter ADDR_WIDTH, default 32, width of all address buses.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, maximum WAIT cycles before an error response; legal range 2..255.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 m{0,1}_valid  in  1  requester N presents a request.
REQ-008 m{0,1}_read, m{0,1}_write  in  1 each  operation select.
REQ-009 m{0,1}_addr  in  ADDR_WIDTH  request byte address.
REQ-010 m{0,1}_data  in  DATA_WIDTH  write data.
REQ-011 m{0,1}_ready  out  1  request accepted on this edge when valid is also high.
REQ-012 m{0,1}_resp_valid  out  1  one-cycle response strobe.
REQ-013 m{0,1}_resp_data  out  DATA_WIDTH  read data.
REQ-014 m{0,1}_resp_err  out  1  response is an error; qualified by resp_valid.
REQ-015 s_valid_o, s_read_o, s_write_o  out  1 each  shared slave-bus command.
REQ-016 s_addr_o  out  ADDR_WIDTH; s_data_o  out  DATA_WIDTH  slave-bus address and write data.
REQ-017 s_valid_i  in  1; s_data_i  in  DATA_WIDTH  slave completion and read data.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, WAIT; exactly one transaction outstanding at any time.
REQ-019 In IDLE, mN_ready SHALL be combinational: high only for the port selected by arbitration while its valid is high; both low in ISSUE and WAIT.
REQ-020 Arbitration: single requester wins; both requesting -> port not equal to last_grant wins (round-robin).
REQ-021 On accept edge: latch addr, data, read, write, grant id; last_grant updated to the granted port.
REQ-022 Legal op (exactly one of read/write set) -> ISSUE; illegal op (both or neither) -> stay IDLE, no slave access, resp_valid=1, resp_err=1, resp_data=0 to granted port in next cycle.
REQ-023 ISSUE: s_valid_o=1 with latched read/write/addr/data for exactly one cycle, timeout counter cleared -> WAIT.
REQ-024 s_* command outputs SHALL be 0 whenever s_valid_o=0.
REQ-025 WAIT: s_valid_i=1 -> registered resp_valid=1, resp_err=0, resp_data=s_data_i to granted port only -> IDLE; write completions also return s_data_i.
REQ-026 WAIT: counter increments per cycle; reaching TIMEOUT_CYCLES-1 without s_valid_i -> resp_valid=1, resp_err=1, resp_data=0 -> IDLE; s_valid_i on that same cycle wins (normal response).
REQ-027 s_valid_i in IDLE or ISSUE SHALL be ignored (no response, no state change).
REQ-028 Response timing: accept edge E; s_valid_o high cycle E+1; slave with 1-cycle latency -> resp_valid high in cycle E+3; next accept possible at edge E+3 (3-cycle throughput).
REQ-029 resp_valid SHALL be a single-cycle pulse; resp_data and resp_err hold until the next response to that port.
REQ-030 Non-granted port's response outputs SHALL remain unchanged during another port's transaction.

Reset
REQ-031 reset_n low SHALL immediately force IDLE, counter 0, last_grant=1 (port 0 wins first tie), all outputs 0, independent of clk.
REQ-032 Reset asserted mid-transaction SHALL abandon it silently; a late s_valid_i after release is ignored per REQ-027.

Verification
REQ-033 Port 0 read addr 0x10 (RAM holds 0xDEADBEEF), port 1 idle -> s_valid_o at E+1, s_addr_o=0x10, m0_resp_valid at E+3, m0_resp_data=0xDEADBEEF, err=0.
REQ-034 Both ports valid from reset, continuous -> grants 0,1,0,1 at 3-cycle spacing; each port sees resp only for its own request.
REQ-035 Port 1 write 0x12345678 to 0x20, then port 0 read 0x20 -> m0_resp_data=0x12345678.
REQ-036 Slave never asserts s_valid_i, TIMEOUT_CYCLES=16 -> m0_resp_valid with err=1, data=0 after 16 WAIT cycles; FSM back in IDLE accepting new requests.
REQ-037 Port 0 request with read=write=1 -> no s_valid_o, m0_resp_valid=1 err=1 next cycle.
REQ-038 reset_n pulsed low during WAIT -> outputs 0 without clock edge; subsequent s_valid_i produces no response; next tie grants port 0.

Source files
------------

// File: rtl/w0rm_data_bus_arbiter_if.sv
// Signal bundle for the two-requester arbiter and its shared slave bus.
// master: the arbiter's view (it masters the shared bus); slave: requesters plus slave device.
interface w0rm_data_bus_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  m0_valid;
    logic                  m0_read;
    logic                  m0_write;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_data;
    logic                  m0_ready;
    logic                  m0_resp_valid;
    logic [DATA_WIDTH-1:0] m0_resp_data;
    logic                  m0_resp_err;

    logic                  m1_valid;
    logic                  m1_read;
    logic                  m1_write;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_data;
    logic                  m1_ready;
    logic                  m1_resp_valid;
    logic [DATA_WIDTH-1:0] m1_resp_data;
    logic                  m1_resp_err;

    logic                  s_valid_o;
    logic                  s_read_o;
    logic                  s_write_o;
    logic [ADDR_WIDTH-1:0] s_addr_o;
    logic [DATA_WIDTH-1:0] s_data_o;
    logic                  s_valid_i;
    logic [DATA_WIDTH-1:0] s_data_i;

    modport master (
        input  m0_valid, m0_read, m0_write, m0_addr, m0_data,
        output m0_ready, m0_resp_valid, m0_resp_data, m0_resp_err,
        input  m1_valid, m1_read, m1_write, m1_addr, m1_data,
        output m1_ready, m1_resp_valid, m1_resp_data, m1_resp_err,
        output s_valid_o, s_read_o, s_write_o, s_addr_o, s_data_o,
        input  s_valid_i, s_data_i
    );

    modport slave (
        output m0_valid, m0_read, m0_write, m0_addr, m0_data,
        input  m0_ready, m0_resp_valid, m0_resp_data, m0_resp_err,
        output m1_valid, m1_read, m1_write, m1_addr, m1_data,
        input  m1_ready, m1_resp_valid, m1_resp_data, m1_resp_err,
        input  s_valid_o, s_read_o, s_write_o, s_addr_o, s_data_o,
        output s_valid_i, s_data_i
    );
endinterface

// File: rtl/w0rm_data_bus_arbiter.sv
// Two-port round-robin arbiter onto a single-outstanding shared slave bus,
// with illegal-op rejection and a WAIT timeout that returns an error response.
module w0rm_data_bus_arbiter #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    w0rm_data_bus_arbiter_if.master bus
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  gnt_q, gnt_d;

    logic                  s_valid_q, s_valid_d;
    logic                  s_read_q, s_read_d;
    logic                  s_write_q, s_write_d;
    logic [ADDR_WIDTH-1:0] s_addr_q, s_addr_d;
    logic [DATA_WIDTH-1:0] s_data_q, s_data_d;

    logic [1:0]            resp_valid_q, resp_valid_d;
    logic [1:0]            resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0] resp_data_q [2];
    logic [DATA_WIDTH-1:0] resp_data_d [2];

    // Requester ports folded into arrays so the FSM can index by grant id
    logic [1:0]            req_valid;
    logic [1:0]            req_read;
    logic [1:0]            req_write;
    logic [ADDR_WIDTH-1:0] req_addr [2];
    logic [DATA_WIDTH-1:0] req_data [2];

    assign req_valid   = {bus.m1_valid, bus.m0_valid};
    assign req_read    = {bus.m1_read, bus.m0_read};
    assign req_write   = {bus.m1_write, bus.m0_write};
    assign req_addr[0] = bus.m0_addr;
    assign req_addr[1] = bus.m1_addr;
    assign req_data[0] = bus.m0_data;
    assign req_data[1] = bus.m1_data;

    logic sel_c;
    logic accept_c;
    logic legal_c;

    // Round-robin pick: a tie goes to the port that did not win last time
    always_comb begin
        sel_c    = req_valid[1];
        if (req_valid == 2'b11) begin
            sel_c = ~last_grant_q;
        end
        accept_c = (state_q == IDLE) && (|req_valid);
        legal_c  = req_read[sel_c] ^ req_write[sel_c];
    end

    // Ready is combinational in IDLE; forced low while reset is asserted
    assign bus.m0_ready = reset_n & accept_c & ~sel_c;
    assign bus.m1_ready = reset_n & accept_c & sel_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            last_grant_q   <= 1'b1;
            gnt_q          <= 1'b0;
            s_valid_q      <= 1'b0;
            s_read_q       <= 1'b0;
            s_write_q      <= 1'b0;
            s_addr_q       <= '0;
            s_data_q       <= '0;
            resp_valid_q   <= '0;
            resp_err_q     <= '0;
            resp_data_q[0] <= '0;
            resp_data_q[1] <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_grant_q   <= last_grant_d;
            gnt_q          <= gnt_d;
            s_valid_q      <= s_valid_d;
            s_read_q       <= s_read_d;
            s_write_q      <= s_write_d;
            s_addr_q       <= s_addr_d;
            s_data_q       <= s_data_d;
            resp_valid_q   <= resp_valid_d;
            resp_err_q     <= resp_err_d;
            resp_data_q[0] <= resp_data_d[0];
            resp_data_q[1] <= resp_data_d[1];
        end
    end

    // Next state and next registered outputs; slave command defaults to all-zero
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        last_grant_d   = last_grant_q;
        gnt_d          = gnt_q;
        s_valid_d      = 1'b0;
        s_read_d       = 1'b0;
        s_write_d      = 1'b0;
        s_addr_d       = '0;
        s_data_d       = '0;
        resp_valid_d   = '0;
        resp_err_d     = resp_err_q;
        resp_data_d[0] = resp_data_q[0];
        resp_data_d[1] = resp_data_q[1];

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    last_grant_d = sel_c;
                    gnt_d        = sel_c;
                    if (legal_c) begin
                        state_d   = ISSUE;
                        s_valid_d = 1'b1;
                        s_read_d  = req_read[sel_c];
                        s_write_d = req_write[sel_c];
                        s_addr_d  = req_addr[sel_c];
                        s_data_d  = req_data[sel_c];
                    end else begin
                        resp_valid_d[sel_c] = 1'b1;
                        resp_err_d[sel_c]   = 1'b1;
                        resp_data_d[sel_c]  = '0;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.s_valid_i) begin
                    resp_valid_d[gnt_q] = 1'b1;
                    resp_err_d[gnt_q]   = 1'b0;
                    resp_data_d[gnt_q]  = bus.s_data_i;
                    cnt_d               = '0;
                    state_d             = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    resp_valid_d[gnt_q] = 1'b1;
                    resp_err_d[gnt_q]   = 1'b1;
                    resp_data_d[gnt_q]  = '0;
                    cnt_d               = '0;
                    state_d             = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.s_valid_o     = s_valid_q;
    assign bus.s_read_o      = s_read_q;
    assign bus.s_write_o     = s_write_q;
    assign bus.s_addr_o      = s_addr_q;
    assign bus.s_data_o      = s_data_q;
    assign bus.m0_resp_valid = resp_valid_q[0];
    assign bus.m0_resp_err   = resp_err_q[0];
    assign bus.m0_resp_data  = resp_data_q[0];
    assign bus.m1_resp_valid = resp_valid_q[1];
    assign bus.m1_resp_err   = resp_err_q[1];
    assign bus.m1_resp_data  = resp_data_q[1];

endmodule

// File: tb/tb_w0rm_data_bus_arbiter.sv
// Scoreboard bench for w0rm_data_bus_arbiter: directed requests push expected
// grants, slave commands and responses; one negedge monitor pops and compares.
module tb_w0rm_data_bus_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    w0rm_data_bus_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    w0rm_data_bus_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    typedef struct { int port; logic [31:0] data; logic err; int lat; } resp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic rd; logic wr; } cmd_t;
    typedef struct { int port; int gap; } grant_t;

    resp_t  exp_resp [$];
    cmd_t   exp_cmd [$];
    grant_t exp_grant [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc [2] = '{-100, -100};
    int prev_acc = -100;
    logic [31:0] last_data [2] = '{32'h0, 32'h0};
    logic        last_err [2]  = '{1'b0, 1'b0};
    bit   mute = 1'b0;
    logic [31:0] mem [64];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic get_rv(input int p);
        return (p == 0) ? bus.m0_resp_valid : bus.m1_resp_valid;
    endfunction
    function automatic logic [31:0] get_rd(input int p);
        return (p == 0) ? bus.m0_resp_data : bus.m1_resp_data;
    endfunction
    function automatic logic get_re(input int p);
        return (p == 0) ? bus.m0_resp_err : bus.m1_resp_err;
    endfunction
    function automatic logic get_acc(input int p);
        return (p == 0) ? (bus.m0_ready & bus.m0_valid) : (bus.m1_ready & bus.m1_valid);
    endfunction

    task automatic exp_g(input int p, input int gap);
        grant_t g; g.port = p; g.gap = gap; exp_grant.push_back(g);
    endtask
    task automatic exp_c(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr);
        cmd_t c; c.addr = a; c.data = d; c.rd = rd; c.wr = wr; exp_cmd.push_back(c);
    endtask
    task automatic exp_r(input int p, input logic [31:0] d, input logic err, input int lat);
        resp_t r; r.port = p; r.data = d; r.err = err; r.lat = lat; exp_resp.push_back(r);
    endtask

    always @(posedge clk) cyc++;

    // Slave device: 1-cycle latency, write data echoed back on completion
    initial begin
        bus.s_valid_i = 1'b0;
        bus.s_data_i  = '0;
        forever begin
            @(negedge clk);
            if (bus.s_valid_o && !mute) begin
                logic [31:0] rdata;
                if (bus.s_write_o) begin
                    mem[bus.s_addr_o[7:2]] = bus.s_data_o;
                    rdata = bus.s_data_o;
                end else begin
                    rdata = mem[bus.s_addr_o[7:2]];
                end
                @(posedge clk); #1;
                bus.s_valid_i = 1'b1;
                bus.s_data_i  = rdata;
                @(posedge clk); #1;
                bus.s_valid_i = 1'b0;
                bus.s_data_i  = '0;
            end
        end
    end

    // Monitor: responses first, then slave command, then grants (fixed order)
    initial begin
        resp_t e; cmd_t c; grant_t g;
        forever begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (get_rv(p)) begin
                    if (exp_resp.size() == 0) begin
                        check($sformatf("unexpected_resp_m%0d", p), 64'(get_rv(p)), 64'd0);
                    end else begin
                        e = exp_resp.pop_front();
                        check("resp_port", 64'(p), 64'(e.port));
                        check($sformatf("resp_data_m%0d", p), 64'(get_rd(p)), 64'(e.data));
                        check($sformatf("resp_err_m%0d", p), 64'(get_re(p)), 64'(e.err));
                        if (e.lat >= 0)
                            check($sformatf("resp_latency_m%0d", p), 64'(cyc - last_acc[p]), 64'(e.lat));
                        last_data[p] = e.data;
                        last_err[p]  = e.err;
                    end
                end else begin
                    check($sformatf("hold_data_m%0d", p), 64'(get_rd(p)), 64'(last_data[p]));
                    check($sformatf("hold_err_m%0d", p), 64'(get_re(p)), 64'(last_err[p]));
                end
            end
            if (bus.s_valid_o) begin
                if (exp_cmd.size() == 0) begin
                    check("unexpected_s_valid_o", 64'(bus.s_valid_o), 64'd0);
                end else begin
                    c = exp_cmd.pop_front();
                    check("s_addr_o", 64'(bus.s_addr_o), 64'(c.addr));
                    check("s_data_o", 64'(bus.s_data_o), 64'(c.data));
                    check("s_read_o", 64'(bus.s_read_o), 64'(c.rd));
                    check("s_write_o", 64'(bus.s_write_o), 64'(c.wr));
                    check("s_valid_timing", 64'(cyc), 64'(prev_acc));
                end
            end else begin
                check("s_idle_zero", {60'd0, bus.s_read_o, bus.s_write_o, |bus.s_addr_o, |bus.s_data_o}, 64'd0);
            end
            check("ready_onehot", 64'(bus.m0_ready & bus.m1_ready), 64'd0);
            for (int p = 0; p < 2; p++) begin
                if (get_acc(p)) begin
                    if (exp_grant.size() == 0) begin
                        check($sformatf("unexpected_grant_m%0d", p), 64'(get_acc(p)), 64'd0);
                    end else begin
                        g = exp_grant.pop_front();
                        check("grant_port", 64'(p), 64'(g.port));
                        if (g.gap >= 0) check("grant_gap", 64'(cyc + 1 - prev_acc), 64'(g.gap));
                    end
                    last_acc[p] = cyc + 1;
                    prev_acc    = cyc + 1;
                end
            end
        end
    end

    task automatic align();
        @(posedge clk); #1;
    endtask

    // Present one request (caller sits just after a rising edge); hold until accepted
    task automatic drive(input int p, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
        bit got = 1'b0;
        int n = 0;
        if (p == 0) begin
            bus.m0_read = rd; bus.m0_write = wr; bus.m0_addr = addr; bus.m0_data = data; bus.m0_valid = 1'b1;
        end else begin
            bus.m1_read = rd; bus.m1_write = wr; bus.m1_addr = addr; bus.m1_data = data; bus.m1_valid = 1'b1;
        end
        while (!got && n < 200) begin
            @(negedge clk);
            got = (p == 0) ? bus.m0_ready : bus.m1_ready;
            n++;
        end
        if (!got) check($sformatf("accept_timeout_m%0d", p), 64'(n), 64'd0);
        @(posedge clk); #1;
        if (p == 0) bus.m0_valid = 1'b0; else bus.m1_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_resp.size() + exp_cmd.size() + exp_grant.size()) != 0 && n < 100) begin
            @(posedge clk); n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("drain_pending", 64'(exp_resp.size() + exp_cmd.size() + exp_grant.size()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, {62'd0, bus.m0_ready, bus.m1_ready}, 64'd0);
        check({tag, "_resp_valid"}, {62'd0, bus.m0_resp_valid, bus.m1_resp_valid}, 64'd0);
        check({tag, "_resp_err"}, {62'd0, bus.m0_resp_err, bus.m1_resp_err}, 64'd0);
        check({tag, "_resp_data"}, {bus.m0_resp_data, bus.m1_resp_data}, 64'd0);
        check({tag, "_s_cmd"}, {61'd0, bus.s_valid_o, bus.s_read_o, bus.s_write_o}, 64'd0);
        check({tag, "_s_bus"}, {bus.s_addr_o, bus.s_data_o}, 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;
        mem[5] = 32'h0BADF00D;
        mem[6] = 32'h11112222;
        mem[7] = 32'h33334444;
        bus.m0_valid = 1'b0; bus.m0_read = 1'b0; bus.m0_write = 1'b0; bus.m0_addr = '0; bus.m0_data = '0;
        bus.m1_valid = 1'b0; bus.m1_read = 1'b0; bus.m1_write = 1'b0; bus.m1_addr = '0; bus.m1_data = '0;

        #12;
        check_all_zero("reset_state");
        @(negedge clk);
        reset_n = 1'b1;

        // Both ports busy from reset: grants 0,1,0,1 at 3-cycle spacing
        exp_g(0, -1); exp_g(1, 3); exp_g(0, 3); exp_g(1, 3);
        exp_c(32'h10, 32'h0, 1'b1, 1'b0); exp_c(32'h14, 32'h0, 1'b1, 1'b0);
        exp_c(32'h18, 32'h0, 1'b1, 1'b0); exp_c(32'h1C, 32'h0, 1'b1, 1'b0);
        exp_r(0, 32'hDEADBEEF, 1'b0, 2); exp_r(1, 32'h0BADF00D, 1'b0, 2);
        exp_r(0, 32'h11112222, 1'b0, 2); exp_r(1, 32'h33334444, 1'b0, 2);
        align();
        fork
            begin drive(0, 1'b1, 1'b0, 32'h10, 32'h0); drive(0, 1'b1, 1'b0, 32'h18, 32'h0); end
            begin drive(1, 1'b1, 1'b0, 32'h14, 32'h0); drive(1, 1'b1, 1'b0, 32'h1C, 32'h0); end
        join
        drain();

        // Single port-0 read
        exp_g(0, -1); exp_c(32'h10, 32'h0, 1'b1, 1'b0); exp_r(0, 32'hDEADBEEF, 1'b0, 2);
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        drain();

        // Illegal ops: read+write on port 0, neither on port 1
        exp_g(0, -1); exp_r(0, 32'h0, 1'b1, 0);
        exp_g(1, -1); exp_r(1, 32'h0, 1'b1, 0);
        drive(0, 1'b1, 1'b1, 32'h40, 32'hFFFF0000);
        drive(1, 1'b0, 1'b0, 32'h44, 32'h0000FFFF);
        drain();

        // Port 1 writes, port 0 reads it back
        exp_g(1, -1); exp_c(32'h20, 32'h12345678, 1'b0, 1'b1); exp_r(1, 32'h12345678, 1'b0, 2);
        drive(1, 1'b0, 1'b1, 32'h20, 32'h12345678);
        exp_g(0, -1); exp_c(32'h20, 32'h0, 1'b1, 1'b0); exp_r(0, 32'h12345678, 1'b0, 2);
        drive(0, 1'b1, 1'b0, 32'h20, 32'h0);
        drain();

        // Silent slave: error after 16 WAIT cycles, then normal service resumes
        mute = 1'b1;
        exp_g(0, -1); exp_c(32'h30, 32'h0, 1'b1, 1'b0); exp_r(0, 32'h0, 1'b1, 17);
        drive(0, 1'b1, 1'b0, 32'h30, 32'h0);
        drain();
        mute = 1'b0;
        exp_g(0, -1); exp_c(32'h14, 32'h0, 1'b1, 1'b0); exp_r(0, 32'h0BADF00D, 1'b0, 2);
        drive(0, 1'b1, 1'b0, 32'h14, 32'h0);
        drain();

        // Completion on the final WAIT cycle beats the timeout
        mute = 1'b1;
        exp_g(0, -1); exp_c(32'h34, 32'h0, 1'b1, 1'b0); exp_r(0, 32'hCAFEF00D, 1'b0, 17);
        drive(0, 1'b1, 1'b0, 32'h34, 32'h0);
        repeat (16) @(posedge clk);
        #1;
        bus.s_valid_i = 1'b1; bus.s_data_i = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.s_valid_i = 1'b0; bus.s_data_i = '0;
        drain();

        // Reset in WAIT: outputs clear at once, late completion ignored
        exp_g(0, -1); exp_c(32'h38, 32'h0, 1'b1, 1'b0);
        drive(0, 1'b1, 1'b0, 32'h38, 32'h0);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        last_data[0] = 32'h0; last_data[1] = 32'h0;
        last_err[0]  = 1'b0;  last_err[1]  = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        bus.s_valid_i = 1'b1; bus.s_data_i = 32'h55AA55AA;
        repeat (2) @(posedge clk);
        #1;
        bus.s_valid_i = 1'b0; bus.s_data_i = '0;
        repeat (3) @(posedge clk);
        #1;
        mute = 1'b0;

        // First tie after reset goes to port 0
        exp_g(0, -1); exp_g(1, 3);
        exp_c(32'h10, 32'h0, 1'b1, 1'b0); exp_c(32'h14, 32'h0, 1'b1, 1'b0);
        exp_r(0, 32'hDEADBEEF, 1'b0, 2); exp_r(1, 32'h0BADF00D, 1'b0, 2);
        fork
            drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
            drive(1, 1'b1, 1'b0, 32'h14, 32'h0);
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
